// File: rtl/ppu_pkg.sv
// Shared PPU definitions: STAT mode encodings and STAT enable bit positions.
// Used by the LCD timing block, the register file and the pixel pipeline.
package ppu_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } ppu_mode_e;

  localparam int STAT_IE_HBLANK = 0;
  localparam int STAT_IE_VBLANK = 1;
  localparam int STAT_IE_OAM    = 2;
  localparam int STAT_IE_LYC    = 3;

endpackage

// File: rtl/ppu_lcd_timing.sv
// LCD dot/line timing: mode sequencing, LY compare and STAT/VBlank requests.
// All outputs are registered or derived from registered state.
module ppu_lcd_timing
  import ppu_pkg::*;
#(
  parameter int H_TOTAL    = 456,
  parameter int V_ACTIVE   = 144,
  parameter int V_TOTAL    = 154,
  parameter int OAM_CYCLES = 80,
  parameter int XFER_MAX   = 289
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lcd_en,
  input  logic [7:0]                 lyc,
  input  logic [3:0]                 stat_ie,
  input  logic                       xfer_done,
  output logic [7:0]                 ly,
  output logic [$clog2(H_TOTAL)-1:0] dot,
  output logic [1:0]                 mode,
  output logic                       coin,
  output logic                       stat_irq,
  output logic                       vblank_irq,
  output logic                       hs,
  output logic                       vs
);

  localparam int DW = $clog2(H_TOTAL);

  localparam logic [DW-1:0] DOT_LAST = DW'(H_TOTAL - 1);
  localparam logic [DW-1:0] DOT_OAM  = DW'(OAM_CYCLES);
  localparam logic [DW-1:0] DOT_XEND = DW'(OAM_CYCLES + XFER_MAX - 1);
  localparam logic [7:0]    LY_LAST  = 8'(V_TOTAL - 1);
  localparam logic [7:0]    LY_VBL   = 8'(V_ACTIVE);

  ppu_mode_e     mode_q, mode_d;
  logic [DW-1:0] dot_q, dot_d;
  logic [7:0]    ly_q, ly_d;
  logic          run_q, run_d;
  logic          coin_q, coin_d;
  logic          hist_q, hist_d;
  logic          sirq_q, sirq_d;
  logic          virq_q, virq_d;
  logic          eol;
  logic          stat_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_HBLANK;
      dot_q  <= '0;
      ly_q   <= '0;
      run_q  <= 1'b0;
      coin_q <= 1'b0;
      hist_q <= 1'b0;
      sirq_q <= 1'b0;
      virq_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dot_q  <= dot_d;
      ly_q   <= ly_d;
      run_q  <= run_d;
      coin_q <= coin_d;
      hist_q <= hist_d;
      sirq_q <= sirq_d;
      virq_q <= virq_d;
    end
  end

  assign eol = (dot_q == DOT_LAST);

  // run_q gates the STAT line so a disabled LCD never raises a request
  assign stat_line = run_q & (
      (stat_ie[STAT_IE_LYC]    & coin_q) |
      (stat_ie[STAT_IE_OAM]    & (mode_q == MODE_OAM)) |
      (stat_ie[STAT_IE_VBLANK] & (mode_q == MODE_VBLANK)) |
      (stat_ie[STAT_IE_HBLANK] & (mode_q == MODE_HBLANK)));

  always_comb begin
    run_d  = lcd_en;
    dot_d  = '0;
    ly_d   = '0;
    mode_d = MODE_HBLANK;
    virq_d = 1'b0;
    if (lcd_en && !run_q) begin
      mode_d = MODE_OAM;
    end else if (lcd_en) begin
      dot_d  = eol ? '0 : dot_q + DW'(1);
      ly_d   = ly_q;
      mode_d = mode_q;
      if (eol) begin
        ly_d   = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
        mode_d = (ly_d < LY_VBL) ? MODE_OAM : MODE_VBLANK;
        virq_d = (ly_d == LY_VBL);
      end else begin
        unique case (mode_q)
          MODE_OAM:
            if (dot_d == DOT_OAM) mode_d = MODE_XFER;
          MODE_XFER:
            if (xfer_done || dot_q == DOT_XEND) mode_d = MODE_HBLANK;
          default: ;
        endcase
      end
    end
    // compare against the next LY so coin lines up with the line itself
    coin_d = (ly_d == lyc);
    hist_d = lcd_en & stat_line;
    sirq_d = lcd_en & stat_line & ~hist_q;
  end

  assign ly         = ly_q;
  assign dot        = dot_q;
  assign mode       = mode_q;
  assign coin       = coin_q;
  assign stat_irq   = sirq_q;
  assign vblank_irq = virq_q;
  assign hs         = run_q & (mode_q == MODE_HBLANK) & (ly_q < LY_VBL);
  assign vs         = run_q & (mode_q == MODE_VBLANK);

endmodule

// File: tb/tb_ppu_lcd_timing.sv
// Directed bench for ppu_lcd_timing at default parameters.
// Position is tracked by cycle count k since the first enabled cycle.
module tb_ppu_lcd_timing;

  localparam int HT    = 456;
  localparam int FRAME = HT * 154;

  logic       clk = 1'b0;
  logic       rst, lcd_en, xfer_done;
  logic [7:0] lyc, ly;
  logic [3:0] stat_ie;
  logic [8:0] dot;
  logic [1:0] mode;
  logic       coin, stat_irq, vblank_irq, hs, vs;

  int n_pass  = 0;
  int n_total = 0;
  int k       = 0;

  ppu_lcd_timing dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lyc(lyc),
    .stat_ie(stat_ie), .xfer_done(xfer_done), .ly(ly), .dot(dot),
    .mode(mode), .coin(coin), .stat_irq(stat_irq),
    .vblank_irq(vblank_irq), .hs(hs), .vs(vs)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    k += n;
  endtask

  task automatic goto(input int l, input int d);
    int n;
    n = l * HT + d - (k % FRAME);
    if (n < 0) n += FRAME;
    adv(n);
  endtask

  task automatic test_reset;
    logic [22:0] v;
    rst = 1'b1; lcd_en = 1'b1; xfer_done = 1'b0;
    lyc = 8'd0; stat_ie = 4'hF;
    adv(2);
    v = {ly, dot, mode, coin, stat_irq, vblank_irq, hs, vs};
    n_total++;
    if (v !== 23'd0) $display("FAIL reset_outputs got=%h exp=0", v);
    else n_pass++;
    rst = 1'b0; lcd_en = 1'b0;
    adv(2);
    n_total++;
    if (coin !== 1'b1) $display("FAIL dis_coin got=%b exp=1", coin);
    else n_pass++;
    n_total++;
    if ({mode, hs, vs, stat_irq} !== 5'd0)
      $display("FAIL dis_quiet got=%b exp=0", {mode, hs, vs, stat_irq});
    else n_pass++;
  endtask

  task automatic enable_fresh;
    lcd_en = 1'b0;
    adv(1);
    lcd_en = 1'b1;
    adv(1);
    k = 0;
    n_total++;
    if ({ly, dot, mode} !== {8'd0, 9'd0, 2'd2})
      $display("FAIL first_en got ly=%0d dot=%0d mode=%0d exp 0/0/2",
               ly, dot, mode);
    else n_pass++;
  endtask

  task automatic test_line_timing;
    logic [1:0] em;
    stat_ie = 4'h0; lyc = 8'd200;
    enable_fresh();
    for (int d = 0; d < HT; d++) begin
      em = (d < 80) ? 2'd2 : (d < 369) ? 2'd3 : 2'd0;
      n_total++;
      if (dot !== 9'(d) || mode !== em || ly !== 8'd0)
        $display("FAIL line0 got ly=%0d dot=%0d mode=%0d exp 0/%0d/%0d",
                 ly, dot, mode, d, em);
      else n_pass++;
      adv(1);
    end
    n_total++;
    if ({ly, dot, mode} !== {8'd1, 9'd0, 2'd2})
      $display("FAIL line_wrap got ly=%0d dot=%0d mode=%0d exp 1/0/2",
               ly, dot, mode);
    else n_pass++;
  endtask

  task automatic test_xfer_done;
    goto(5, 252);
    n_total++;
    if ({mode, hs} !== {2'd3, 1'b0})
      $display("FAIL pre_done got mode=%0d hs=%b exp 3/0", mode, hs);
    else n_pass++;
    xfer_done = 1'b1;
    adv(1);
    xfer_done = 1'b0;
    for (int d = 253; d < HT; d++) begin
      n_total++;
      if ({dot, mode, hs} !== {9'(d), 2'd0, 1'b1})
        $display("FAIL hblank got dot=%0d mode=%0d hs=%b exp %0d/0/1",
                 dot, mode, hs, d);
      else n_pass++;
      adv(1);
    end
    n_total++;
    if ({ly, mode, hs} !== {8'd6, 2'd2, 1'b0})
      $display("FAIL next_line got ly=%0d mode=%0d hs=%b exp 6/2/0",
               ly, mode, hs);
    else n_pass++;
    goto(6, 10);
    xfer_done = 1'b1;
    adv(1);
    xfer_done = 1'b0;
    n_total++;
    if (mode !== 2'd2) $display("FAIL oam_ignore got=%0d exp=2", mode);
    else n_pass++;
    goto(6, 80);
    n_total++;
    if (mode !== 2'd3) $display("FAIL xfer_entry got=%0d exp=3", mode);
    else n_pass++;
    goto(6, 400);
    xfer_done = 1'b1;
    adv(1);
    xfer_done = 1'b0;
    n_total++;
    if (mode !== 2'd0) $display("FAIL hbl_ignore got=%0d exp=0", mode);
    else n_pass++;
  endtask

  task automatic test_coin;
    int n, np, ppos;
    goto(9, 400);
    lyc = 8'd10; stat_ie = 4'b1000;
    adv(1);
    n = 11 * HT - (k % FRAME);
    np = 0; ppos = -1;
    for (int i = 0; i <= n; i++) begin
      n_total++;
      if (coin !== ((k % FRAME) / HT == 10))
        $display("FAIL coin got=%b at ly=%0d dot=%0d", coin, ly, dot);
      else n_pass++;
      if (stat_irq === 1'b1) begin np++; ppos = k % FRAME; end
      if (i < n) adv(1);
    end
    n_total++;
    if (np !== 1 || ppos !== 10 * HT + 1)
      $display("FAIL lyc_irq got n=%0d pos=%0d exp 1/%0d",
               np, ppos, 10 * HT + 1);
    else n_pass++;
    goto(12, 5);
    lyc = 8'd12;
    n_total++;
    if (coin !== 1'b0) $display("FAIL lyc_wr_pre got=%b exp=0", coin);
    else n_pass++;
    adv(1);
    n_total++;
    if (coin !== 1'b1) $display("FAIL lyc_wr got=%b exp=1", coin);
    else n_pass++;
    lyc = 8'd200;
    adv(1);
    n_total++;
    if (coin !== 1'b0) $display("FAIL lyc_clr got=%b exp=0", coin);
    else n_pass++;
    stat_ie = 4'h0;
  endtask

  task automatic test_frame;
    int n, nv, vpos, el;
    n = FRAME - (k % FRAME);
    nv = 0; vpos = -1;
    for (int i = 0; i < n; i++) begin
      adv(1);
      el = (k % FRAME) / HT;
      if (vblank_irq === 1'b1) begin nv++; vpos = k % FRAME; end
      if (el >= 144) begin
        n_total++;
        if ({mode, vs, hs} !== {2'd1, 1'b1, 1'b0})
          $display("FAIL vblank got ly=%0d mode=%0d vs=%b hs=%b exp 1/1/0",
                   ly, mode, vs, hs);
        else n_pass++;
      end
    end
    n_total++;
    if (nv !== 1 || vpos !== 144 * HT)
      $display("FAIL vbl_irq got n=%0d pos=%0d exp 1/%0d", nv, vpos, 144 * HT);
    else n_pass++;
    n_total++;
    if ({ly, dot, mode, vs} !== {8'd0, 9'd0, 2'd2, 1'b0})
      $display("FAIL frame_wrap got ly=%0d dot=%0d mode=%0d vs=%b exp 0/0/2/0",
               ly, dot, mode, vs);
    else n_pass++;
  endtask

  task automatic test_stat_adjacent;
    int pk[$];
    stat_ie = 4'b0101; lyc = 8'd200;
    for (int i = 0; i < 2 * HT; i++) begin
      if (stat_irq === 1'b1) pk.push_back(k % FRAME);
      adv(1);
    end
    n_total++;
    if (pk.size() !== 3)
      $display("FAIL stat_count got=%0d exp=3", pk.size());
    else n_pass++;
    if (pk.size() == 3) begin
      n_total++;
      if (pk[0] !== 1 || pk[1] !== 370 || pk[2] !== HT + 370)
        $display("FAIL stat_pos got=%0d,%0d,%0d exp=1,370,826",
                 pk[0], pk[1], pk[2]);
      else n_pass++;
    end
    stat_ie = 4'b0001;
  endtask

  task automatic test_disable;
    logic [23:0] v;
    goto(50, 200);
    n_total++;
    if ({ly, mode} !== {8'd50, 2'd3})
      $display("FAIL pre_drop got ly=%0d mode=%0d exp 50/3", ly, mode);
    else n_pass++;
    lcd_en = 1'b0; lyc = 8'd0;
    for (int i = 0; i < 10; i++) begin
      adv(1);
      v = {ly, dot, mode, hs, vs, stat_irq, vblank_irq};
      n_total++;
      if (v !== 24'd0) $display("FAIL disabled got=%h exp=0", v);
      else n_pass++;
    end
    n_total++;
    if (coin !== 1'b1) $display("FAIL dis_coin2 got=%b exp=1", coin);
    else n_pass++;
    lcd_en = 1'b1;
    adv(1);
    k = 0;
    n_total++;
    if ({ly, dot, mode, vblank_irq, stat_irq} !== {8'd0, 9'd0, 2'd2, 2'b00})
      $display("FAIL reenable got ly=%0d dot=%0d mode=%0d vi=%b si=%b",
               ly, dot, mode, vblank_irq, stat_irq);
    else n_pass++;
    adv(1);
    n_total++;
    if ({dot, vblank_irq} !== {9'd1, 1'b0})
      $display("FAIL reen_adv got dot=%0d vi=%b exp 1/0", dot, vblank_irq);
    else n_pass++;
  endtask

  task automatic test_rst_midline;
    goto(0, 100);
    n_total++;
    if ({dot, mode} !== {9'd100, 2'd3})
      $display("FAIL pre_rst got dot=%0d mode=%0d exp 100/3", dot, mode);
    else n_pass++;
    rst = 1'b1;
    adv(2);
    n_total++;
    if ({ly, dot, mode, hs, coin} !== {8'd0, 9'd0, 2'd0, 2'b00})
      $display("FAIL in_rst got ly=%0d dot=%0d mode=%0d hs=%b coin=%b",
               ly, dot, mode, hs, coin);
    else n_pass++;
    rst = 1'b0;
    adv(1);
    k = 0;
    n_total++;
    if ({ly, dot, mode} !== {8'd0, 9'd0, 2'd2})
      $display("FAIL post_rst got ly=%0d dot=%0d mode=%0d exp 0/0/2",
               ly, dot, mode);
    else n_pass++;
    adv(1);
    n_total++;
    if (dot !== 9'd1) $display("FAIL post_rst_adv got=%0d exp=1", dot);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_xfer_done();
    test_coin();
    test_frame();
    test_stat_adjacent();
    test_disable();
    test_rst_midline();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
